// File: rtl/rule_conf_mstage.sv
// Multi-stage parser rule configurator: field writes go to per-stage shadows, a commit publishes one stage.
// Optional shadow readback port is compiled in when RULE_CONF_RDBK_EN is defined.
package parser_pkg;
    localparam int unsigned TYPE_NUM          = 4;
    localparam int unsigned KEY_FIELD_NUM     = 8;
    localparam int unsigned TYPE_WIDTH        = 16;
    localparam int unsigned TYPE_OFFSET_WIDTH = 8;
    localparam int unsigned KEY_OFFSET_WIDTH  = 8;
    localparam int unsigned HEAD_SHIFT_WIDTH  = 8;
    localparam int unsigned META_SHIFT_WIDTH  = 8;

    typedef struct packed {
        logic                                        typeRule_valid;
        logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]         typeData;
        logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]         typeMask;
        logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]  typeOffset;
        logic [KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH:0] keyOffset;
        logic [HEAD_SHIFT_WIDTH-1:0]                 headShift;
        logic [META_SHIFT_WIDTH-1:0]                 metaShift;
    } type_rule_t;
endpackage

module rule_conf_mstage
    import parser_pkg::*;
#(
    parameter int unsigned STAGE_NUM = 4,
    parameter int unsigned RULE_NUM  = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rule_wren,
    input  logic [31:0]                   i_rule_wdata,
    input  logic [31:0]                   i_rule_addr,
    output logic                          o_rule_ready,
    output logic [2:0]                    o_cfg_err,
    output logic [STAGE_NUM*RULE_NUM-1:0] o_typeRule_wren,
    output type_rule_t [STAGE_NUM-1:0]    o_type_rule,
    input  logic                          i_rule_rden,
    output logic [31:0]                   o_rule_rdata,
    output logic                          o_rule_rvalid
);
    localparam int unsigned SW  = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
    localparam int unsigned RW  = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
    localparam int unsigned TIW = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
    localparam int unsigned KIW = (KEY_FIELD_NUM > 1) ? $clog2(KEY_FIELD_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_PULSE} state_t;

    state_t                        r_state, w_state_nxt;
    type_rule_t [STAGE_NUM-1:0]    r_shadow;
    type_rule_t                    w_commit_rule;
    logic [SW-1:0]                 r_cs;
    logic [RW-1:0]                 r_cr;
    logic [2:0]                    r_err, w_err_set, w_err_clr;
    logic                          w_accept, w_commit;
    logic [STAGE_NUM*RULE_NUM-1:0] r_wren, w_wren_sel;
    logic [3:0]                    w_stage;
    logic [2:0]                    w_op;
    logic [5:0]                    w_idx;
    logic [SW-1:0]                 w_sidx;
    logic                          w_unused_addr;

    assign w_stage       = i_rule_addr[15:12];
    assign w_op          = i_rule_addr[10:8];
    assign w_idx         = i_rule_addr[5:0];
    assign w_sidx        = w_stage[SW-1:0];
    assign w_unused_addr = ^{i_rule_addr[31:16], i_rule_addr[11], i_rule_addr[7:6]};

    // Error priority: busy, then stage range, then per-op index range
    always_comb begin
        w_err_set = '0;
        w_accept  = 1'b0;
        if (i_rule_wren) begin
            if (r_state != S_IDLE) begin
                w_err_set[2] = 1'b1;
            end else if (w_op != 3'd7 && 32'(w_stage) >= STAGE_NUM) begin
                w_err_set[0] = 1'b1;
            end else begin
                case (w_op)
                    3'd0:       w_err_set[1] = (32'(w_idx) >= RULE_NUM);
                    3'd1, 3'd2: w_err_set[1] = (32'(w_idx) >= TYPE_NUM);
                    3'd3:       w_err_set[1] = (32'(w_idx) >= KEY_FIELD_NUM);
                    default:    w_err_set[1] = 1'b0;
                endcase
                w_accept = ~w_err_set[1];
            end
        end
        w_commit  = w_accept && (w_op == 3'd0);
        w_err_clr = (w_accept && w_op == 3'd7) ? i_rule_wdata[2:0] : '0;
        w_commit_rule                = r_shadow[w_sidx];
        w_commit_rule.typeRule_valid = i_rule_wdata[0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_rule_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_rule_ready = 1'b1;
                if (w_commit) w_state_nxt = S_COMMIT;
            end
            S_COMMIT: w_state_nxt = S_PULSE;
            S_PULSE:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wren_sel = '0;
        for (int unsigned s = 0; s < STAGE_NUM; s++) begin
            for (int unsigned r = 0; r < RULE_NUM; r++) begin
                if (r_cs == SW'(s) && r_cr == RW'(r)) w_wren_sel[s*RULE_NUM+r] = 1'b1;
            end
        end
    end

    // The rule is published on the edge entering COMMIT, so it is already stable while wren pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow    <= '0;
            o_type_rule <= '0;
            r_cs        <= '0;
            r_cr        <= '0;
            r_err       <= '0;
            r_wren      <= '0;
        end else begin
            r_err  <= (r_err & ~w_err_clr) | w_err_set;
            r_wren <= (r_state == S_COMMIT) ? w_wren_sel : '0;
            if (w_commit) begin
                o_type_rule[w_sidx] <= w_commit_rule;
                r_cs                <= w_sidx;
                r_cr                <= w_idx[RW-1:0];
            end
            if (w_accept) begin
                case (w_op)
                    3'd1: begin
                        r_shadow[w_sidx].typeData[w_idx[TIW-1:0]] <= i_rule_wdata[16 +: TYPE_WIDTH];
                        r_shadow[w_sidx].typeMask[w_idx[TIW-1:0]] <= i_rule_wdata[0 +: TYPE_WIDTH];
                    end
                    3'd2: r_shadow[w_sidx].typeOffset[w_idx[TIW-1:0]] <= i_rule_wdata[0 +: TYPE_OFFSET_WIDTH];
                    3'd3: r_shadow[w_sidx].keyOffset[w_idx[KIW-1:0]] <=
                              {i_rule_wdata[16], i_rule_wdata[0 +: KEY_OFFSET_WIDTH]};
                    3'd4: r_shadow[w_sidx].headShift <= i_rule_wdata[0 +: HEAD_SHIFT_WIDTH];
                    3'd5: r_shadow[w_sidx].metaShift <= i_rule_wdata[0 +: META_SHIFT_WIDTH];
                    default: ;
                endcase
            end
        end
    end

    assign o_cfg_err       = r_err;
    assign o_typeRule_wren = r_wren;

`ifdef RULE_CONF_RDBK_EN
    logic [31:0] w_rdata, r_rdata;
    logic        r_rvalid;

    always_comb begin
        w_rdata = '0;
        if (w_op == 3'd7) begin
            w_rdata[2:0] = r_err;
        end else if (32'(w_stage) < STAGE_NUM) begin
            case (w_op)
                3'd0: begin
                    w_rdata[31]    = o_rule_ready;
                    w_rdata[30:28] = r_err;
                    w_rdata[0]     = o_type_rule[w_sidx].typeRule_valid;
                end
                3'd1: if (32'(w_idx) < TYPE_NUM) begin
                    w_rdata[16 +: TYPE_WIDTH] = r_shadow[w_sidx].typeData[w_idx[TIW-1:0]];
                    w_rdata[0 +: TYPE_WIDTH]  = r_shadow[w_sidx].typeMask[w_idx[TIW-1:0]];
                end
                3'd2: if (32'(w_idx) < TYPE_NUM)
                    w_rdata[0 +: TYPE_OFFSET_WIDTH] = r_shadow[w_sidx].typeOffset[w_idx[TIW-1:0]];
                3'd3: if (32'(w_idx) < KEY_FIELD_NUM) begin
                    w_rdata[16] = r_shadow[w_sidx].keyOffset[w_idx[KIW-1:0]][KEY_OFFSET_WIDTH];
                    w_rdata[0 +: KEY_OFFSET_WIDTH] =
                        r_shadow[w_sidx].keyOffset[w_idx[KIW-1:0]][KEY_OFFSET_WIDTH-1:0];
                end
                3'd4: w_rdata[0 +: HEAD_SHIFT_WIDTH] = r_shadow[w_sidx].headShift;
                3'd5: w_rdata[0 +: META_SHIFT_WIDTH] = r_shadow[w_sidx].metaShift;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_rule_rden;
            if (i_rule_rden) r_rdata <= w_rdata;
        end
    end

    assign o_rule_rdata  = r_rdata;
    assign o_rule_rvalid = r_rvalid;
`else
    logic w_unused_rd;
    assign w_unused_rd   = i_rule_rden;
    assign o_rule_rdata  = '0;
    assign o_rule_rvalid = 1'b0;
`endif
endmodule

// File: tb/tb_rule_conf_mstage.sv
// Directed bench for rule_conf_mstage: reference model of shadows/outputs/errors plus a commit-pulse scoreboard.
module tb_rule_conf_mstage;
    import parser_pkg::*;

    logic         i_clk, i_rst_n, i_rule_wren, i_rule_rden;
    logic [31:0]  i_rule_wdata, i_rule_addr;
    logic         o_rule_ready, o_rule_rvalid;
    logic [2:0]   o_cfg_err;
    logic [127:0] o_typeRule_wren;
    type_rule_t [3:0] o_type_rule;
    logic [31:0]  o_rule_rdata;

    rule_conf_mstage #(.STAGE_NUM(4), .RULE_NUM(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rule_wren(i_rule_wren),
        .i_rule_wdata(i_rule_wdata), .i_rule_addr(i_rule_addr),
        .o_rule_ready(o_rule_ready), .o_cfg_err(o_cfg_err),
        .o_typeRule_wren(o_typeRule_wren), .o_type_rule(o_type_rule),
        .i_rule_rden(i_rule_rden), .o_rule_rdata(o_rule_rdata), .o_rule_rvalid(o_rule_rvalid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int           stage;
        int           rule;
        logic [127:0] wren;
    } sb_t;

    sb_t        sb[$];
    type_rule_t m_shadow[4];
    type_rule_t m_out[4];
    logic [2:0] m_err;
    bit         m_busy;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rules(input string tag);
        for (int s = 0; s < 4; s++) chk($sformatf("%s_rule%0d", tag, s), 256'(o_type_rule[s]), 256'(m_out[s]));
    endtask

    function automatic logic [127:0] onehot(input int st, input int r);
        logic [127:0] v;
        v = '0;
        v[st*32+r] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_shadow[s] = '0;
            m_out[s]    = '0;
        end
        m_err  = '0;
        m_busy = 1'b0;
        sb.delete();
    endtask

    task automatic model_wr(input int op, input int st, input int idx, input logic [31:0] d);
        sb_t e;
        if (m_busy) m_err[2] = 1'b1;
        else if (op != 7 && st >= 4) m_err[0] = 1'b1;
        else if ((op == 0 && idx >= 32) || ((op == 1 || op == 2) && idx >= int'(TYPE_NUM)) ||
                 (op == 3 && idx >= int'(KEY_FIELD_NUM))) m_err[1] = 1'b1;
        else begin
            case (op)
                0: begin
                    m_out[st] = m_shadow[st];
                    m_out[st].typeRule_valid = d[0];
                    e.stage = st; e.rule = idx; e.wren = onehot(st, idx);
                    sb.push_back(e);
                    m_busy = 1'b1;
                end
                1: begin
                    m_shadow[st].typeData[idx] = d[31:16];
                    m_shadow[st].typeMask[idx] = d[15:0];
                end
                2: m_shadow[st].typeOffset[idx] = d[7:0];
                3: m_shadow[st].keyOffset[idx]  = {d[16], d[7:0]};
                4: m_shadow[st].headShift       = d[7:0];
                5: m_shadow[st].metaShift       = d[7:0];
                7: m_err = m_err & ~d[2:0];
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_rd(input int op, input int st, input int idx);
        logic [31:0] r;
        r = '0;
        if (op == 7) r[2:0] = m_err;
        else if (st < 4) begin
            case (op)
                0: begin r[31] = !m_busy; r[30:28] = m_err; r[0] = m_out[st].typeRule_valid; end
                1: if (idx < int'(TYPE_NUM)) r = {m_shadow[st].typeData[idx], m_shadow[st].typeMask[idx]};
                2: if (idx < int'(TYPE_NUM)) r[7:0] = m_shadow[st].typeOffset[idx];
                3: if (idx < int'(KEY_FIELD_NUM)) begin
                    r[16] = m_shadow[st].keyOffset[idx][8];
                    r[7:0] = m_shadow[st].keyOffset[idx][7:0];
                end
                4: r[7:0] = m_shadow[st].headShift;
                5: r[7:0] = m_shadow[st].metaShift;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic set_addr(input int op, input int st, input int idx);
        i_rule_addr = {16'h0, st[3:0], 1'b0, op[2:0], 2'b00, idx[5:0]};
    endtask

    task automatic wr(input int op, input int st, input int idx, input logic [31:0] d);
        set_addr(op, st, idx);
        i_rule_wdata = d;
        i_rule_wren  = 1'b1;
        model_wr(op, st, idx, d);
        @(posedge i_clk);
        #1;
        i_rule_wren = 1'b0;
        chk("err", 256'(o_cfg_err), 256'(m_err));
        chk("ready", 256'(o_rule_ready), 256'(!m_busy));
        chk_rules("wr");
    endtask

    task automatic rd(input int op, input int st, input int idx, input bit with_wr,
                      input logic [31:0] d, input string tag);
        logic [31:0] exp;
        exp = model_rd(op, st, idx);
        set_addr(op, st, idx);
        i_rule_rden = 1'b1;
        if (with_wr) begin
            i_rule_wdata = d;
            i_rule_wren  = 1'b1;
            model_wr(op, st, idx, d);
        end
        @(posedge i_clk);
        #1;
        i_rule_rden = 1'b0;
        i_rule_wren = 1'b0;
`ifdef RULE_CONF_RDBK_EN
        chk({tag, "_rvalid"}, 256'(o_rule_rvalid), 256'(1));
        chk({tag, "_rdata"}, 256'(o_rule_rdata), 256'(exp));
`else
        chk({tag, "_rvalid_off"}, 256'(o_rule_rvalid), 256'(0));
        chk({tag, "_rdata_off"}, 256'(o_rule_rdata), 256'(0));
`endif
    endtask

    // Waits (bounded) for the write-enable pulse and scores it against the oldest expected commit
    task automatic wait_pulse(input int exp_lat);
        sb_t e;
        int  lat;
        lat = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            if (o_typeRule_wren !== '0) begin
                lat = c;
                break;
            end
        end
        chk("sb_nonempty", 256'(sb.size() > 0), 256'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pulse_wren", 256'(o_typeRule_wren), 256'(e.wren));
        end
        chk("pulse_lat", 256'(lat), 256'(exp_lat));
        chk("pulse_ready", 256'(o_rule_ready), 256'(0));
        chk_rules("pulse");
        @(negedge i_clk);
        m_busy = 1'b0;
        chk("pulse_len", 256'(o_typeRule_wren), 256'(0));
        chk("ready_back", 256'(o_rule_ready), 256'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        i_rst_n = 1'b0; i_rule_wren = 1'b0; i_rule_rden = 1'b0;
        i_rule_wdata = '0; i_rule_addr = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", 256'(o_rule_ready), 256'(1));
        chk("rst_err", 256'(o_cfg_err), 256'(0));
        chk("rst_wren", 256'(o_typeRule_wren), 256'(0));
        chk("rst_rvalid", 256'(o_rule_rvalid), 256'(0));
        chk("rst_rdata", 256'(o_rule_rdata), 256'(0));
        chk_rules("rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Test 1: type data/mask then commit stage 1 rule 5
        wr(1, 1, 2, 32'h0800_FFFF);
        wr(0, 1, 5, 32'h1);
        chk("t1_data", 256'(o_type_rule[1].typeData[2]), 256'(16'h0800));
        chk("t1_mask", 256'(o_type_rule[1].typeMask[2]), 256'(16'hFFFF));
        wait_pulse(1);

        // Test 2: key offset invisible until commit
        wr(3, 0, 7, 32'h0001_0014);
        wr(0, 0, 0, 32'h1);
        chk("t2_key", 256'(o_type_rule[0].keyOffset[7]), 256'(9'h114));
        wait_pulse(1);

        // Test 3: write while busy is dropped and flagged
        wr(0, 2, 3, 32'h1);
        wr(1, 2, 0, 32'h1234_5678);
        wait_pulse(0);
        wr(7, 0, 0, 32'h4);
        wr(0, 2, 3, 32'h1);
        wait_pulse(1);

        // Test 4: range errors, partial clear, shadow untouched
        wr(1, 5, 0, 32'hDEAD_BEEF);
        wr(1, 1, 4, 32'hDEAD_BEEF);
        wr(3, 1, 8, 32'h0001_00FF);
        wr(0, 1, 32, 32'h1);
        wr(7, 0, 0, 32'h1);
        wr(7, 0, 0, 32'h2);
        wr(0, 1, 5, 32'h1);
        wait_pulse(1);

        // Upper-boundary stage/rule with the remaining field ops
        wr(2, 3, 3, 32'hAB);
        wr(4, 3, 0, 32'h11);
        wr(5, 3, 0, 32'h5A);
        wr(6, 3, 0, 32'hFFFF_FFFF);
        wr(0, 3, 31, 32'h1);
        wait_pulse(1);

        // Test 5: reset during PULSE
        wr(0, 3, 31, 32'h0);
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        chk("t5_wren_pre", 256'(o_typeRule_wren), 256'(e.wren));
        i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_wren_rst", 256'(o_typeRule_wren), 256'(0));
        chk("t5_ready_rst", 256'(o_rule_ready), 256'(1));
        chk_rules("t5");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("t5_ready_rel", 256'(o_rule_ready), 256'(1));
        chk("t5_err_rel", 256'(o_cfg_err), 256'(0));
        wr(0, 1, 5, 32'h1);
        wait_pulse(1);

        // Test 6: readback (or its absence)
        wr(4, 2, 0, 32'h12);
        rd(4, 2, 0, 1'b0, 32'h0, "rd_head");
        rd(4, 2, 0, 1'b1, 32'h34, "rd_rw");
        rd(4, 2, 0, 1'b0, 32'h0, "rd_head2");
        rd(1, 1, 2, 1'b0, 32'h0, "rd_type");
        wr(1, 5, 0, 32'h0);
        rd(7, 0, 0, 1'b0, 32'h0, "rd_err");
        rd(0, 1, 0, 1'b0, 32'h0, "rd_stat");
        @(posedge i_clk);
        #1;
        chk("rd_rvalid_drop", 256'(o_rule_rvalid), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
